spi_bus_sequencer: RTL and testbench

//  Converts frames received by the SPI register slave into transactions on the on-chip register bus.

---
 rtl/spi_bus_sequencer_if.sv | 32 +++
 rtl/spi_bus_sequencer.sv | 162 ++++++++++++++++
 tb/tb_spi_bus_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_bus_sequencer_if
// Description : Register-bus request/response bundle between the SPI frame
//               sequencer (master) and the on-chip register fabric (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_bus_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            be;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/spi_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_bus_sequencer
// Description : Turns completed SPI register frames into a single
//               req/gnt/rvalid transaction on the register bus and reports
//               read data and status back to the SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bus_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spi_ss,
    input  logic [ADDR_WIDTH-1:0]  spi_addr,
    input  logic [DATA_WIDTH-1:0]  spi_din,
    input  logic [DATA_WIDTH-1:0]  spi_misc,
    spi_bus_sequencer_if.master    bus,
    output logic [DATA_WIDTH-1:0]  reg_dout,
    output logic [DATA_WIDTH-1:0]  status
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  ss_q1, ss_q2, ss_q3;
    logic                  frame_end;
    logic                  new_cmd;
    logic                  launch, overrun_evt;
    logic                  gnt_evt, rsp_evt, tmo_evt, timer_expired;
    logic                  req_c;
    logic [CNT_W-1:0]      tmo_cnt;

    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_be;
    logic [7:0]            last_tag;
    logic                  st_busy, st_done, st_berr, st_tmo, st_ovr;

    // Only go/we/be/tag are meaningful in MISC; the rest is reserved.
    logic unused_misc;
    assign unused_misc = ^{spi_misc[DATA_WIDTH-1:16], spi_misc[7:6]};

    // SS crosses from the SPI domain: two flops to resynchronise plus one
    // to detect the rising (deassert) edge that ends a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_q1 <= 1'b1;
            ss_q2 <= 1'b1;
            ss_q3 <= 1'b1;
        end else begin
            ss_q1 <= spi_ss;
            ss_q2 <= ss_q1;
            ss_q3 <= ss_q2;
        end
    end

    assign frame_end   = ss_q2 & ~ss_q3;
    // A frame only counts when go is set and its tag differs from the last
    // launched one, so re-sending a stale MISC word is harmless.
    assign new_cmd     = frame_end & spi_misc[0] & (spi_misc[15:8] != last_tag);
    assign launch      = new_cmd & (state == IDLE);
    assign overrun_evt = new_cmd & (state != IDLE);

    // A handshake arriving on the last allowed cycle wins over the abort.
    assign timer_expired = (tmo_cnt == CNT_LAST);
    assign gnt_evt       = (state == REQ)  & bus.gnt;
    assign rsp_evt       = (state == RESP) & bus.rvalid;
    assign tmo_evt       = ((state == REQ)  & ~bus.gnt    & timer_expired) |
                           ((state == RESP) & ~bus.rvalid & timer_expired);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; bus_req is simply "we are in REQ".
    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        unique case (state)
            IDLE: if (launch) state_nxt = REQ;
            REQ: begin
                req_c = 1'b1;
                if (gnt_evt)      state_nxt = RESP;
                else if (tmo_evt) state_nxt = IDLE;
            end
            RESP: if (rsp_evt || tmo_evt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state watchdog: restarts on every state change, idle in IDLE.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE || state_nxt != state) tmo_cnt <= '0;
        else                                              tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Request capture, read-data return and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            last_tag  <= '0;
            reg_dout  <= '0;
            st_busy   <= 1'b0;
            st_done   <= 1'b0;
            st_berr   <= 1'b0;
            st_tmo    <= 1'b0;
            st_ovr    <= 1'b0;
        end else begin
            if (launch) begin
                req_we    <= spi_misc[1];
                req_be    <= spi_misc[5:2];
                req_addr  <= spi_addr;
                req_wdata <= spi_din;
                last_tag  <= spi_misc[15:8];
                st_busy   <= 1'b1;
                st_done   <= 1'b0;
                st_berr   <= 1'b0;
                st_tmo    <= 1'b0;
                st_ovr    <= 1'b0;
            end
            if (overrun_evt) st_ovr <= 1'b1;
            if (rsp_evt) begin
                st_busy <= 1'b0;
                st_done <= 1'b1;
                st_berr <= bus.err;
                if (!req_we) reg_dout <= bus.rdata;
            end
            if (tmo_evt) begin
                st_busy <= 1'b0;
                st_done <= 1'b1;
                st_tmo  <= 1'b1;
            end
        end
    end

    assign bus.req   = req_c;
    assign bus.we    = req_we;
    assign bus.addr  = req_addr;
    assign bus.wdata = req_wdata;
    assign bus.be    = req_be;

    assign status = DATA_WIDTH'({last_tag, 3'b000, st_ovr, st_tmo, st_berr, st_done, st_busy});

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_bus_sequencer
// Description : Self-checking bench for spi_bus_sequencer: transaction-level
//               reference model compared every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_bus_sequencer;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          spi_ss = 1'b1;
    logic [AW-1:0] spi_addr = '0;
    logic [DW-1:0] spi_din = '0;
    logic [DW-1:0] spi_misc = '0;
    logic          gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] reg_dout, status;

    int checks = 0;
    int errors = 0;

    spi_bus_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();
    assign bus_if.gnt    = gnt;
    assign bus_if.rvalid = rvalid;
    assign bus_if.rdata  = rdata;
    assign bus_if.err    = err;

    spi_bus_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_ss   (spi_ss),
        .spi_addr (spi_addr),
        .spi_din  (spi_din),
        .spi_misc (spi_misc),
        .bus      (bus_if),
        .reg_dout (reg_dout),
        .status   (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = no transaction, 1 = waiting for grant, 2 = waiting for response
    logic [2:0]    m_hist = 3'b111;
    int            m_phase = 0, m_age = 0, m_old = 0;
    logic          m_frame, m_fresh;
    logic [7:0]    m_tag = '0;
    logic          m_we = 0, m_busy = 0, m_done = 0, m_berr = 0, m_tmo = 0, m_ovr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_dout = '0;
    logic [3:0]    m_be = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_hist = 3'b111; m_phase = 0; m_age = 0; m_tag = '0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_dout = '0;
            m_busy = 0; m_done = 0; m_berr = 0; m_tmo = 0; m_ovr = 0;
        end else begin
            m_old   = m_phase;
            m_frame = m_hist[1] && !m_hist[2];
            m_fresh = spi_misc[0] && (spi_misc[15:8] != m_tag);
            if (m_phase == 1) begin
                if (gnt) begin m_phase = 2; m_age = 0; end
                else if (m_age == TMO - 1) begin
                    m_phase = 0; m_age = 0; m_busy = 0; m_done = 1; m_tmo = 1;
                end else m_age++;
            end else if (m_phase == 2) begin
                if (rvalid) begin
                    m_phase = 0; m_age = 0; m_busy = 0; m_done = 1; m_berr = err;
                    if (!m_we) m_dout = rdata;
                end else if (m_age == TMO - 1) begin
                    m_phase = 0; m_age = 0; m_busy = 0; m_done = 1; m_tmo = 1;
                end else m_age++;
            end
            if (m_frame && m_fresh) begin
                if (m_old == 0) begin
                    m_we = spi_misc[1]; m_be = spi_misc[5:2];
                    m_addr = spi_addr; m_wdata = spi_din; m_tag = spi_misc[15:8];
                    m_busy = 1; m_done = 0; m_berr = 0; m_tmo = 0; m_ovr = 0;
                    m_phase = 1; m_age = 0;
                end else m_ovr = 1;
            end
            m_hist = {m_hist[1:0], spi_ss};
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        check("req",      {31'b0, bus_if.req}, {31'b0, m_phase == 1});
        check("we",       {31'b0, bus_if.we}, {31'b0, m_we});
        check("addr",     bus_if.addr, m_addr);
        check("wdata",    bus_if.wdata, m_wdata);
        check("be",       {28'b0, bus_if.be}, {28'b0, m_be});
        check("reg_dout", reg_dout, m_dout);
        check("status",   status, {16'b0, m_tag, 3'b000, m_ovr, m_tmo, m_berr, m_done, m_busy});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        spi_addr = a; spi_din = d; spi_misc = m;
        spi_ss = 1'b0;
        tick(3);
        spi_ss = 1'b1;
    endtask

    task automatic wait_req();
        int lat = 0;
        while (!bus_if.req && lat < 20) begin tick(1); lat++; end
        check("req_seen", {31'b0, bus_if.req}, 32'd1);
        check("latency_le4", {31'b0, lat <= 4}, 32'd1);
    endtask

    task automatic grant(input int dly);
        tick(dly); gnt = 1'b1; tick(1); gnt = 1'b0;
    endtask

    task automatic respond(input int dly, input logic [31:0] d, input logic e);
        tick(dly); rvalid = 1'b1; rdata = d; err = e;
        tick(1); rvalid = 1'b0; err = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        tick(3);
        reset = 1'b0;
        check("rst_status", status, 32'h0);
        check("rst_req", {31'b0, bus_if.req}, 32'd0);
        check("rst_dout", reg_dout, 32'h0);

        // 1: tagged write
        send_frame(32'h1234_1217, 32'hABCD_ABCD, 32'h0000_0103);
        wait_req();
        check("t1_addr", bus_if.addr, 32'h1234_1217);
        check("t1_wdata", bus_if.wdata, 32'hABCD_ABCD);
        check("t1_we", {31'b0, bus_if.we}, 32'd1);
        check("t1_be", {28'b0, bus_if.be}, 32'd0);
        grant(2);
        respond(3, 32'h0, 1'b0);
        tick(2);
        check("t1_status", status, 32'h0000_0102);

        // 2: read, with a stray rvalid while still requesting
        send_frame(32'h0000_0100, 32'h0, 32'h0000_0201);
        wait_req();
        respond(0, 32'h1111_1111, 1'b0);
        grant(0);
        respond(1, 32'hDEAD_BEEF, 1'b0);
        tick(2);
        check("t2_dout", reg_dout, 32'hDEAD_BEEF);
        check("t2_status", status, 32'h0000_0202);
        send_frame(32'h0000_0100, 32'h0, 32'h0000_0201);
        cnt = 0;
        repeat (10) begin tick(1); if (bus_if.req) cnt++; end
        check("t2_repeat_noreq", cnt, 32'd0);

        // 3: no grant -> REQ timeout after exactly TMO cycles
        send_frame(32'h0000_0300, 32'h0, 32'h0000_0301);
        wait_req();
        cnt = 1;
        while (cnt < 40) begin tick(1); if (!bus_if.req) break; cnt++; end
        check("t3_req_cycles", cnt, TMO);
        tick(1);
        check("t3_status", status, 32'h0000_030A);

        // 3b: grant but no response -> RESP timeout
        send_frame(32'h0000_0400, 32'h0, 32'h0000_0401);
        wait_req();
        grant(0);
        tick(TMO + 2);
        check("t3b_status", status, 32'h0000_040A);

        // 4: overrun while waiting for the response
        send_frame(32'h0000_0500, 32'h5555_0000, 32'h0000_0503);
        wait_req();
        grant(0);
        send_frame(32'h0000_0600, 32'h6666_0000, 32'h0000_0603);
        tick(4);
        check("t4_ovr_status", status, 32'h0000_0511);
        check("t4_no_req", {31'b0, bus_if.req}, 32'd0);
        respond(0, 32'h0, 1'b0);
        tick(2);
        check("t4_done_status", status, 32'h0000_0512);
        send_frame(32'h0000_0600, 32'h6666_0000, 32'h0000_0603);
        wait_req();
        check("t4_relaunch", status, 32'h0000_0601);
        grant(0);
        respond(0, 32'h0, 1'b0);
        tick(2);

        // 5: write with bus error; stray grant while idle first
        grant(0);
        send_frame(32'h0000_0700, 32'h7777_7777, 32'h0000_0707);
        wait_req();
        check("t5_be", {28'b0, bus_if.be}, 32'd1);
        grant(1);
        respond(0, 32'h5555_5555, 1'b1);
        tick(2);
        check("t5_status", status, 32'h0000_0706);
        check("t5_dout", reg_dout, 32'hDEAD_BEEF);

        // 6: reset during REQ, late response, relaunch of tag 1
        send_frame(32'h1234_1217, 32'hABCD_ABCD, 32'h0000_0103);
        wait_req();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_req", {31'b0, bus_if.req}, 32'd0);
        check("t6_status", status, 32'h0);
        check("t6_addr", bus_if.addr, 32'h0);
        respond(1, 32'h9999_9999, 1'b0);
        tick(2);
        check("t6_late_rvalid", status, 32'h0);
        send_frame(32'h1234_1217, 32'hABCD_ABCD, 32'h0000_0103);
        wait_req();
        grant(0);
        respond(0, 32'h0, 1'b0);
        tick(2);
        check("t6_relaunch", status, 32'h0000_0102);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
